// File: rtl/srm_pkg.sv
// Shared definitions for the interrupt controller and the regfile transfer path.
package srm_pkg;

    typedef enum logic [0:0] {
        IRQ_IDLE    = 1'b0,
        IRQ_SERVICE = 1'b1
    } irq_state_t;

    localparam logic [31:0]       SRM_VEC_BASE   = 32'h0000_0100;
    localparam logic [31:0]       SRM_VEC_STRIDE = 32'h0000_0010;
    localparam int unsigned       KS_BIT         = 0;
    localparam logic [4:0]        PC_SAVE_REG    = 5'h1d;

    // Vector address of a line; the 32-bit product and sum wrap mod 2^32.
    function automatic logic [31:0] srm_vec_addr(
        input logic [31:0] base,
        input logic [31:0] stride,
        input logic [31:0] idx
    );
        return base + (stride * idx);
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder over the eligible pending lines.
module irq_prio_enc #(
    parameter int unsigned N   = 8,
    parameter int unsigned IDW = 3
) (
    input  logic [N-1:0]   i_eff,
    output logic           o_any_c,
    output logic [IDW-1:0] o_idx_c
);

    // Scan from the top down so the lowest set index is written last.
    always_comb begin
        o_any_c = |i_eff;
        o_idx_c = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (i_eff[i]) begin
                o_idx_c = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-latched pending lines, one transfer pulse per service, held until reti.
// Optional IRQ_MASK_EN adds a per-line mask register with mask_we/mask_din write ports.
module irq_ctrl
    import srm_pkg::*;
#(
    parameter int unsigned NUM_IRQ    = 8,
    parameter logic [31:0] VEC_BASE   = SRM_VEC_BASE,
    parameter logic [31:0] VEC_STRIDE = SRM_VEC_STRIDE,
    localparam int unsigned IDW       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
`ifdef IRQ_MASK_EN
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_din,
`endif
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               irq_en,
    input  logic               boundary,
    input  logic               reti,
    output logic               ir_tsf,
    output logic               ks,
    output logic [31:0]        vec,
    output logic [IDW-1:0]     irq_id,
    output logic               busy,
    output logic [NUM_IRQ-1:0] pending
);

    logic [NUM_IRQ-1:0] r_irq_q;
    logic [NUM_IRQ-1:0] r_pending;
    irq_state_t         r_state;
    logic               r_tsf;
    logic               r_busy;
    logic [31:0]        r_vec;
    logic [IDW-1:0]     r_id;

    logic [NUM_IRQ-1:0] w_new;
    logic [NUM_IRQ-1:0] w_clr;
    logic [NUM_IRQ-1:0] w_mask;
    logic [NUM_IRQ-1:0] w_eff;
    logic               w_any;
    logic [IDW-1:0]     w_win;
    irq_state_t         w_state_nxt;
    logic               w_tsf_nxt;
    logic               w_busy_nxt;
    logic [31:0]        w_vec_nxt;
    logic [IDW-1:0]     w_id_nxt;

    assign w_new = irq & ~r_irq_q;

`ifdef IRQ_MASK_EN
    logic [NUM_IRQ-1:0] r_mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask <= '1;
        end else if (mask_we) begin
            r_mask <= mask_din;
        end
    end

    assign w_mask = r_mask;
`else
    assign w_mask = '1;
`endif

    assign w_eff = r_pending & w_mask;

    irq_prio_enc #(
        .N   (NUM_IRQ),
        .IDW (IDW)
    ) u_prio_enc (
        .i_eff   (w_eff),
        .o_any_c (w_any),
        .o_idx_c (w_win)
    );

    // Next-state and next-output logic; a transfer is only ever taken from IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_tsf_nxt   = 1'b0;
        w_busy_nxt  = r_busy;
        w_vec_nxt   = r_vec;
        w_id_nxt    = r_id;
        w_clr       = '0;
        case (r_state)
            IRQ_IDLE: begin
                if (w_any && irq_en && boundary) begin
                    w_state_nxt = IRQ_SERVICE;
                    w_tsf_nxt   = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_id_nxt    = w_win;
                    w_vec_nxt   = srm_vec_addr(VEC_BASE, VEC_STRIDE, 32'(w_win));
                    w_clr       = NUM_IRQ'(1) << w_win;
                end
            end
            IRQ_SERVICE: begin
                if (reti) begin
                    w_state_nxt = IRQ_IDLE;
                    w_busy_nxt  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IRQ_IDLE;
            r_irq_q   <= '0;
            r_pending <= '0;
            r_tsf     <= 1'b0;
            r_busy    <= 1'b0;
            r_vec     <= '0;
            r_id      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_irq_q   <= irq;
            // A new edge on the line being cleared keeps it pending.
            r_pending <= (r_pending & ~w_clr) | w_new;
            r_tsf     <= w_tsf_nxt;
            r_busy    <= w_busy_nxt;
            r_vec     <= w_vec_nxt;
            r_id      <= w_id_nxt;
        end
    end

    assign ir_tsf  = r_tsf;
    assign ks      = r_tsf;
    assign busy    = r_busy;
    assign vec     = r_vec;
    assign irq_id  = r_id;
    assign pending = r_pending;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus random traffic against a per-line behavioural model.
module tb_irq_ctrl;

    localparam int unsigned N      = 8;
    localparam int unsigned IDW    = 3;
    localparam longint      BASE   = 64'h100;
    localparam longint      STRIDE = 64'h10;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   irq;
    logic           irq_en;
    logic           boundary;
    logic           reti;
    logic           ir_tsf;
    logic           ks;
    logic [31:0]    vec;
    logic [IDW-1:0] irq_id;
    logic           busy;
    logic [N-1:0]   pending;
`ifdef IRQ_MASK_EN
    logic           mask_we;
    logic [N-1:0]   mask_din;
`endif

    always #5 clk = ~clk;

    irq_ctrl dut (
        .clk      (clk),
        .rst      (rst),
`ifdef IRQ_MASK_EN
        .mask_we  (mask_we),
        .mask_din (mask_din),
`endif
        .irq      (irq),
        .irq_en   (irq_en),
        .boundary (boundary),
        .reti     (reti),
        .ir_tsf   (ir_tsf),
        .ks       (ks),
        .vec      (vec),
        .irq_id   (irq_id),
        .busy     (busy),
        .pending  (pending)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_pulse = 0;
    logic prev_tsf = 1'b0;
    logic [N-1:0] irq_v;

    // Behavioural model: one flag per line plus "in service" bookkeeping.
    bit     m_prev [N];
    bit     m_pend [N];
    bit     m_mask [N];
    bit     m_busy;
    bit     m_tsf;
    int     m_id;
    longint m_vec;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_pend_word();
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < int'(N); i++) w[i] = m_pend[i];
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(N); i++) begin
            m_prev[i] = 1'b0;
            m_pend[i] = 1'b0;
            m_mask[i] = 1'b1;
        end
        m_busy = 1'b0;
        m_tsf  = 1'b0;
        m_id   = 0;
        m_vec  = 0;
    endtask

    // Apply the rules for one clock edge using the inputs currently driven.
    task automatic model_step();
        bit nw [N];
        int w;
        w = -1;
        for (int i = 0; i < int'(N); i++) nw[i] = irq[i] && !m_prev[i];
        if (!m_busy && irq_en && boundary) begin
            for (int i = 0; i < int'(N); i++) begin
                if (w < 0 && m_pend[i] && m_mask[i]) w = i;
            end
        end
        m_tsf = (w >= 0);
        if (w >= 0) begin
            m_busy    = 1'b1;
            m_id      = w;
            m_vec     = (BASE + longint'(w) * STRIDE) & 64'hFFFF_FFFF;
            m_pend[w] = 1'b0;
        end else if (m_busy && reti) begin
            m_busy = 1'b0;
        end
        for (int i = 0; i < int'(N); i++) begin
            if (nw[i]) m_pend[i] = 1'b1;
            m_prev[i] = irq[i];
        end
`ifdef IRQ_MASK_EN
        if (mask_we) begin
            for (int i = 0; i < int'(N); i++) m_mask[i] = mask_din[i];
        end
`endif
    endtask

    task automatic compare_all();
        check_eq("ir_tsf", 32'(ir_tsf), 32'(m_tsf));
        check_eq("ks", 32'(ks), 32'(m_tsf));
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("pending", 32'(pending), model_pend_word());
        if (m_busy) begin
            check_eq("vec", vec, 32'(m_vec));
            check_eq("irq_id", 32'(irq_id), 32'(m_id));
        end
        if (prev_tsf) check_eq("tsf_back_to_back", 32'(ir_tsf), 32'd0);
        prev_tsf = ir_tsf;
        if (ir_tsf) n_pulse++;
    endtask

    task automatic cycle(input logic [N-1:0] i_irq, input bit en, input bit bd, input bit rt);
        @(negedge clk);
        irq_v    = i_irq;
        irq      = i_irq;
        irq_en   = en;
        boundary = bd;
        reti     = rt;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic drive_idle_inputs();
        irq_v    = '0;
        irq      = '0;
        irq_en   = 1'b0;
        boundary = 1'b0;
        reti     = 1'b0;
`ifdef IRQ_MASK_EN
        mask_we  = 1'b0;
        mask_din = '1;
`endif
    endtask

    task automatic check_zero_outputs(input string pfx);
        check_eq({pfx, "_ir_tsf"}, 32'(ir_tsf), 32'd0);
        check_eq({pfx, "_ks"}, 32'(ks), 32'd0);
        check_eq({pfx, "_busy"}, 32'(busy), 32'd0);
        check_eq({pfx, "_pending"}, 32'(pending), 32'd0);
        check_eq({pfx, "_vec"}, vec, 32'd0);
        check_eq({pfx, "_irq_id"}, 32'(irq_id), 32'd0);
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        prev_tsf = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive_idle_inputs();
        model_reset();
        #1;
        check_zero_outputs("reset");
        release_reset();

        // Single line: pulse one cycle after the pending bit is seen.
        n_pulse = 0;
        cycle(8'h08, 1, 1, 0);
        cycle(8'h08, 1, 1, 0);
        check_eq("t1_tsf", 32'(ir_tsf), 32'd1);
        check_eq("t1_vec", vec, 32'h130);
        check_eq("t1_id", 32'(irq_id), 32'd3);
        check_eq("t1_pend3", 32'(pending[3]), 32'd0);
        cycle(8'h08, 1, 1, 0);
        cycle(8'h00, 1, 0, 1);
        cycle(8'h00, 1, 0, 0);
        check_eq("t1_pulses", 32'(n_pulse), 32'd1);

        // Simultaneous lines 1 and 5: lowest index first, the other after reti.
        n_pulse = 0;
        cycle(8'h22, 1, 0, 0);
        cycle(8'h22, 1, 1, 0);
        check_eq("t2_vec_first", vec, 32'h110);
        repeat (3) cycle(8'h22, 1, 1, 0);
        cycle(8'h22, 1, 1, 1);
        cycle(8'h22, 1, 1, 0);
        check_eq("t2_vec_second", vec, 32'h150);
        cycle(8'h22, 1, 1, 1);
        repeat (4) cycle(8'h22, 1, 1, 0);
        check_eq("t2_pulses", 32'(n_pulse), 32'd2);

        // Level held high retriggers nothing; a fresh edge during service does.
        cycle(8'h00, 1, 0, 0);
        n_pulse = 0;
        repeat (20) cycle(8'h04, 1, 1, 0);
        check_eq("t3_held_pulses", 32'(n_pulse), 32'd1);
        cycle(8'h00, 1, 1, 0);
        cycle(8'h04, 1, 1, 0);
        check_eq("t3_repend", 32'(pending[2]), 32'd1);
        cycle(8'h04, 1, 1, 1);
        cycle(8'h04, 1, 1, 0);
        cycle(8'h04, 1, 1, 1);
        check_eq("t3_pulses", 32'(n_pulse), 32'd2);

        // Gating by irq_en and boundary.
        cycle(8'h00, 1, 0, 0);
        n_pulse = 0;
        cycle(8'h10, 0, 1, 0);
        repeat (3) cycle(8'h10, 0, 1, 0);
        repeat (3) cycle(8'h10, 1, 0, 0);
        check_eq("t4_gated", 32'(n_pulse), 32'd0);
        cycle(8'h10, 1, 1, 0);
        check_eq("t4_tsf", 32'(ir_tsf), 32'd1);
        check_eq("t4_vec", vec, 32'h140);
        cycle(8'h00, 1, 0, 1);

        // Asynchronous reset in the middle of a service.
        cycle(8'h01, 1, 1, 0);
        cycle(8'h01, 1, 1, 0);
        cycle(8'h41, 1, 0, 0);
        check_eq("t5_busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        drive_idle_inputs();
        #1;
        check_zero_outputs("t5");
        model_reset();
        release_reset();
        n_pulse = 0;
        repeat (5) cycle(8'h00, 1, 1, 0);
        check_eq("t5_no_pulse", 32'(n_pulse), 32'd0);

`ifdef IRQ_MASK_EN
        // Masked line latches but is not eligible until unmasked.
        @(negedge clk);
        mask_we  = 1'b1;
        mask_din = 8'hFE;
        cycle(8'h00, 1, 1, 0);
        mask_we  = 1'b0;
        n_pulse  = 0;
        repeat (4) cycle(8'h01, 1, 1, 0);
        check_eq("t6_masked", 32'(n_pulse), 32'd0);
        check_eq("t6_pend0", 32'(pending[0]), 32'd1);
        mask_din = 8'hFF;
        mask_we  = 1'b1;
        cycle(8'h01, 1, 1, 0);
        mask_we  = 1'b0;
        cycle(8'h01, 1, 1, 0);
        check_eq("t6_vec", vec, 32'h100);
        check_eq("t6_pulses", 32'(n_pulse), 32'd1);
        cycle(8'h00, 1, 0, 1);
`endif

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            logic [N-1:0] nv;
            bit en, bd, rt;
            nv = irq_v ^ N'($urandom & $urandom & $urandom);
            en = ($urandom % 8) != 0;
            bd = ($urandom % 3) != 0;
            rt = m_busy ? (($urandom % 6) == 0) : (($urandom % 20) == 0);
`ifdef IRQ_MASK_EN
            mask_we  = ($urandom % 25) == 0;
            mask_din = N'($urandom | $urandom);
`endif
            cycle(nv, en, bd, rt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
